fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the word-addressed, asynchronous-read code memory.
- Owns the PC and drives the memory's word index.
- Latches the returned instruction into the IF/ID pipeline register.
- Handles start, stall, branch/jump redirect and the halt sentinel word; sits between the code memory and the decode stage.

---
 rtl/fetch_ctrl_pkg.sv | 25 ++
 rtl/fetch_pc_sel.sv | 39 +++
 rtl/fetch_ctrl.sv | 143 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-stage definitions: default geometry, halt sentinel, state and next-PC encodings.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_ctrl_pkg;

    localparam int          DEPTH_DEF     = 256;
    localparam int          AW_DEF        = 8;
    localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

    // Fetch sequencer states; value 3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_RUN  = 2'd1,
        FS_HALT = 2'd2
    } fetch_state_t;

    // Next-PC source selection.
    typedef enum logic [1:0] {
        PC_HOLD  = 2'd0,
        PC_INC   = 2'd1,
        PC_REDIR = 2'd2,
        PC_RESET = 2'd3
    } pc_sel_t;

endpackage

// File: rtl/fetch_pc_sel.sv
// Next-PC mux: hold, increment with wrap at DEPTH, redirect target, or restart vector.
// Latency: purely combinational.
// Backpressure: none; the caller encodes stall as a hold select.
module fetch_pc_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int DEPTH    = fetch_ctrl_pkg::DEPTH_DEF,
    parameter int AW       = fetch_ctrl_pkg::AW_DEF,
    parameter int RESET_PC = 0
) (
    input  pc_sel_t       sel,
    input  logic [AW-1:0] pc,
    input  logic [AW-1:0] redirect_pc,
    output logic [AW-1:0] next_pc
);

    logic [AW-1:0] pc_inc;

    // Sequential successor; explicit wrap so a non-power-of-two DEPTH still works.
    always_comb begin
        pc_inc = pc + AW'(1);
        if (pc == AW'(DEPTH - 1)) begin
            pc_inc = '0;
        end
    end

    // Select the next PC source.
    always_comb begin
        next_pc = pc;
        case (sel)
            PC_HOLD:  next_pc = pc;
            PC_INC:   next_pc = pc_inc;
            PC_REDIR: next_pc = redirect_pc;
            PC_RESET: next_pc = AW'(RESET_PC);
            default:  next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, reads async code memory, fills IF/ID; optional FETCH_PERF_EN counters.
// Latency: word at imem_pc lands in IF/ID one clock later; 1 instruction/cycle without stalls.
// Backpressure: stall freezes PC and IF/ID; redirect squashes the wrong-path word and wins over stall.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int          DEPTH     = fetch_ctrl_pkg::DEPTH_DEF,
    parameter int          AW        = fetch_ctrl_pkg::AW_DEF,
    parameter int          RESET_PC  = 0,
    parameter logic [31:0] HALT_WORD = fetch_ctrl_pkg::HALT_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_instr,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid,
    output logic        halted
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    fetch_state_t  state, state_n;
    pc_sel_t       sel;
    logic [AW-1:0] pc, pc_n;
    logic [31:0]   ifid_instr_n;
    logic [31:0]   ifid_pc_n;
    logic          ifid_valid_n;
    logic          fetch_evt;
    logic          stall_evt;
    logic          start_acc;
    logic          unused_redirect_hi;

    // Only the low AW bits of the redirect target address the memory.
    assign unused_redirect_hi = ^redirect_pc[31:AW];

    assign imem_pc = {{(32 - AW){1'b0}}, pc};
    assign halted  = (state == FS_HALT);

    fetch_pc_sel #(
        .DEPTH    (DEPTH),
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc_sel (
        .sel         (sel),
        .pc          (pc),
        .redirect_pc (redirect_pc[AW-1:0]),
        .next_pc     (pc_n)
    );

    // Next state, PC select and IF/ID update with redirect > stall > halt > fetch priority.
    always_comb begin
        state_n      = state;
        sel          = PC_HOLD;
        ifid_instr_n = ifid_instr;
        ifid_pc_n    = ifid_pc;
        ifid_valid_n = ifid_valid;
        fetch_evt    = 1'b0;
        stall_evt    = 1'b0;
        start_acc    = 1'b0;
        case (state)
            FS_IDLE, FS_HALT: begin
                ifid_valid_n = 1'b0;
                if (start) begin
                    state_n   = FS_RUN;
                    sel       = PC_RESET;
                    start_acc = 1'b1;
                end
            end
            FS_RUN: begin
                if (redirect_valid) begin
                    sel          = PC_REDIR;
                    ifid_valid_n = 1'b0;
                end else if (stall) begin
                    stall_evt = 1'b1;
                end else if (imem_instr == HALT_WORD) begin
                    state_n      = FS_HALT;
                    ifid_valid_n = 1'b0;
                end else begin
                    sel          = PC_INC;
                    ifid_instr_n = imem_instr;
                    ifid_pc_n    = imem_pc;
                    ifid_valid_n = 1'b1;
                    fetch_evt    = 1'b1;
                end
            end
            default: begin
                state_n      = FS_IDLE;
                sel          = PC_RESET;
                ifid_valid_n = 1'b0;
            end
        endcase
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FS_IDLE;
            pc         <= AW'(RESET_PC);
            ifid_instr <= '0;
            ifid_pc    <= '0;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            ifid_instr <= ifid_instr_n;
            ifid_pc    <= ifid_pc_n;
            ifid_valid <= ifid_valid_n;
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating fetch/stall counters, cleared when a start is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else if (start_acc) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (fetch_evt && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall_evt && (perf_stalls != 32'hFFFF_FFFF)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = fetch_evt ^ stall_evt ^ start_acc;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed vector bench for fetch_ctrl with a behavioural code memory.
// Latency: checks one cycle after each driven cycle.
// Backpressure: exercises stall, redirect, halt, wrap and async reset.
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] imem_pc;
    logic [31:0] imem_instr;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
    logic        halted;

    logic [31:0] mem [256];

    int n_checks;
    int n_fail;

    typedef struct {
        logic        st;
        logic        sl;
        logic        rv;
        logic [31:0] rp;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [31:0] e_imem;
        logic        e_halted;
    } vec_t;

    vec_t vecs[$];

    fetch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_pc        (imem_pc),
        .imem_instr     (imem_instr),
        .ifid_instr     (ifid_instr),
        .ifid_pc        (ifid_pc),
        .ifid_valid     (ifid_valid),
        .halted         (halted)
    );

    assign imem_instr = mem[imem_pc[7:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] iw(input int n);
        return (n == 44) ? 32'h0 : (32'h1000_0000 + 32'(n));
    endfunction

    function automatic vec_t mk(input logic st, input logic sl, input logic rv, input int rp,
                                input logic ev, input int epc, input logic [31:0] ei,
                                input int eim, input logic eh);
        vec_t v;
        v.st = st; v.sl = sl; v.rv = rv; v.rp = 32'(rp);
        v.e_valid = ev; v.e_pc = 32'(epc); v.e_instr = ei;
        v.e_imem = 32'(eim); v.e_halted = eh;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [31:0] epc,
                           input logic [31:0] ei, input logic [31:0] eim, input logic eh);
        chk({tag, ".ifid_valid"}, 32'(ifid_valid), 32'(ev));
        chk({tag, ".ifid_pc"},    ifid_pc,         epc);
        chk({tag, ".ifid_instr"}, ifid_instr,      ei);
        chk({tag, ".imem_pc"},    imem_pc,         eim);
        chk({tag, ".halted"},     32'(halted),     32'(eh));
    endtask

    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            start          = vecs[i].st;
            stall          = vecs[i].sl;
            redirect_valid = vecs[i].rv;
            redirect_pc    = vecs[i].rp;
            @(posedge clk);
            #1;
            chk_all($sformatf("%s[%0d]", tag, i), vecs[i].e_valid, vecs[i].e_pc,
                    vecs[i].e_instr, vecs[i].e_imem, vecs[i].e_halted);
        end
        start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 256; i++) mem[i] = iw(i);
        mem[29] = 32'hFFFF_FFFF;

        start = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        rst = 1'b1;
        #1;
        chk_all("reset", 1'b0, 0, 32'h0, 0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //           st  sl  rv  rp    ev  epc  instr      imem eh
        vecs.push_back(mk(0, 0, 0, 0,   0, 0,   32'h0,     0,   0)); // idle
        vecs.push_back(mk(0, 1, 1, 5,   0, 0,   32'h0,     0,   0)); // idle ignores stall/redirect
        vecs.push_back(mk(1, 0, 0, 0,   0, 0,   32'h0,     0,   0)); // start
        vecs.push_back(mk(0, 0, 0, 0,   1, 0,   iw(0),     1,   0));
        vecs.push_back(mk(1, 0, 0, 0,   1, 1,   iw(1),     2,   0)); // start in RUN ignored
        vecs.push_back(mk(0, 0, 0, 0,   1, 2,   iw(2),     3,   0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 2,   iw(2),     3,   0)); // stall x3
        vecs.push_back(mk(0, 1, 0, 0,   1, 2,   iw(2),     3,   0));
        vecs.push_back(mk(0, 1, 0, 0,   1, 2,   iw(2),     3,   0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 3,   iw(3),     4,   0)); // release
        vecs.push_back(mk(0, 1, 1, 20,  0, 3,   iw(3),     20,  0)); // redirect beats stall
        vecs.push_back(mk(0, 0, 0, 0,   1, 20,  iw(20),    21,  0));
        vecs.push_back(mk(0, 0, 1, 27,  0, 20,  iw(20),    27,  0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 27,  iw(27),    28,  0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 28,  iw(28),    29,  0));
        vecs.push_back(mk(0, 0, 0, 0,   0, 28,  iw(28),    29,  1)); // halt word seen
        vecs.push_back(mk(0, 1, 1, 5,   0, 28,  iw(28),    29,  1)); // halt ignores stall/redirect
        vecs.push_back(mk(0, 0, 0, 0,   0, 28,  iw(28),    29,  1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 28,  iw(28),    0,   0)); // restart
        vecs.push_back(mk(0, 0, 0, 0,   1, 0,   iw(0),     1,   0));
        vecs.push_back(mk(0, 0, 1, 300, 0, 0,   iw(0),     44,  0)); // low AW bits only
        vecs.push_back(mk(0, 0, 0, 0,   1, 44,  32'h0,     45,  0)); // zero word is valid
        vecs.push_back(mk(0, 0, 1, 255, 0, 44,  32'h0,     255, 0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 255, iw(255),   0,   0)); // wrap
        vecs.push_back(mk(0, 0, 0, 0,   1, 0,   iw(0),     1,   0));
        vecs.push_back(mk(0, 0, 1, 29,  0, 0,   iw(0),     29,  0));
        vecs.push_back(mk(0, 1, 0, 0,   0, 0,   iw(0),     29,  0)); // stall outranks halt
        vecs.push_back(mk(0, 0, 0, 0,   0, 0,   iw(0),     29,  1));
        vecs.push_back(mk(1, 0, 0, 0,   0, 0,   iw(0),     0,   0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 0,   iw(0),     1,   0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 1,   iw(1),     2,   0));
        run_vecs("vec");

        // Asynchronous reset between edges while running.
        #2;
        rst = 1'b1;
        #1;
        chk_all("arst", 1'b0, 0, 32'h0, 0, 1'b0);
        #1;
        rst = 1'b0;
        vecs.delete();
        vecs.push_back(mk(0, 0, 0, 0,   0, 0,   32'h0,     0,   0)); // back in IDLE
        vecs.push_back(mk(1, 0, 0, 0,   0, 0,   32'h0,     0,   0));
        vecs.push_back(mk(0, 0, 0, 0,   1, 0,   iw(0),     1,   0));
        run_vecs("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
